// File: rtl/dense_output_layer.sv
`default_nettype none
// ============================================================================
// Module   : dense_output_layer
// Purpose  : Final fully-connected layer. Streams in an N_IN-element Q8.8
//            activation vector, runs one signed multiply-accumulate per cycle
//            (neuron-major), then publishes N_OUT saturated Q8.8 logits as one
//            packed vector with a single-cycle valid pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_data/in_valid/in_ready - activation stream (valid/ready)
//            w_we/w_addr/w_data  - weight write port, index o*N_IN+i
//            b_we/b_addr/b_data  - bias write port, index o
//            busy                - frame in progress (parameter writes ignored)
//            neuron_outputs      - packed logits, neuron o at [o*16 +: 16]
//            out_valid           - one-cycle pulse when neuron_outputs update
// Revision : 1.0 - initial release
// ============================================================================
module dense_output_layer #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 10,
  parameter bit RELU  = 1'b0,
  localparam int WA = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1,
  localparam int BA = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  w_we,
  input  logic [WA-1:0]         w_addr,
  input  logic [15:0]           w_data,
  input  logic                  b_we,
  input  logic [BA-1:0]         b_addr,
  input  logic [15:0]           b_data,
  output logic                  busy,
  output logic [N_OUT*16-1:0]   neuron_outputs,
  output logic                  out_valid
);

  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned W_DEPTH = N_OUT * N_IN;
  localparam logic [KW-1:0] I_MAX = KW'(N_IN - 1);
  localparam logic [BA-1:0] O_MAX = BA'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [15:0] x_mem [N_IN];
  logic [15:0] w_mem [N_OUT*N_IN];
  logic [15:0] b_mem [N_OUT];

  logic [KW-1:0]               k;
  logic [KW-1:0]               i;
  logic [BA-1:0]               o;
  logic signed [39:0]          acc;
  logic [N_OUT-1:0][15:0]      res;

  logic                        accept;
  logic                        k_last;
  logic                        i_last;
  logic                        o_last;
  logic [31:0]                 w_idx;
  logic signed [15:0]          w_rd;
  logic signed [15:0]          x_rd;
  logic signed [15:0]          b_rd;
  logic signed [31:0]          prod;
  logic signed [39:0]          sum;
  logic signed [39:0]          shifted;
  logic signed [39:0]          biased;
  logic [15:0]                 fin;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD) || (k != '0);
  assign accept   = in_valid && in_ready;
  assign k_last   = (k == I_MAX);
  assign i_last   = (i == I_MAX);
  assign o_last   = (o == O_MAX);

  // ---------------------------------------------------------------------------
  // MAC datapath and neuron finalisation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_idx   = 32'(o) * 32'(N_IN) + 32'(i);
    w_rd    = w_mem[w_idx[WA-1:0]];
    x_rd    = x_mem[i];
    b_rd    = b_mem[o];
    prod    = w_rd * x_rd;
    sum     = acc + {{8{prod[31]}}, prod};
    // Arithmetic shift floors toward -inf, dropping the extra 8 fraction bits.
    shifted = sum >>> 8;
    biased  = shifted + {{24{b_rd[15]}}, b_rd};
    if (biased > 40'sd32767) begin
      fin = 16'h7FFF;
    end else if (biased < -40'sd32768) begin
      fin = 16'h8000;
    end else begin
      fin = biased[15:0];
    end
    if (RELU && fin[15]) begin
      fin = 16'h0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: activations, weights, biases. Not cleared by reset; parameter
  // writes are only honoured while no frame is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      x_mem[k] <= in_data;
    end
    if (w_we && !busy && (32'(w_addr) < W_DEPTH)) begin
      w_mem[w_addr] <= w_data;
    end
    if (b_we && !busy && (32'(b_addr) < 32'(N_OUT))) begin
      b_mem[b_addr] <= b_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:    if (accept && k_last) state_nx = S_COMPUTE;
      S_COMPUTE: if (i_last && o_last) state_nx = S_DONE;
      S_DONE:    state_nx = S_LOAD;
      default:   state_nx = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, accumulator, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k              <= '0;
      i              <= '0;
      o              <= '0;
      acc            <= '0;
      res            <= '0;
      neuron_outputs <= '0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            k <= k_last ? '0 : k + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (i_last) begin
            res[o] <= fin;
            acc    <= '0;
            i      <= '0;
            o      <= o_last ? '0 : o + 1'b1;
          end else begin
            acc <= sum;
            i   <= i + 1'b1;
          end
        end
        S_DONE: begin
          // All lanes publish together so the consumer never sees a mixed frame.
          neuron_outputs <= res;
          out_valid      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_output_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_output_layer
// Purpose  : Directed self-checking bench for dense_output_layer. Three
//            instances: N_IN=4 (RELU=0 and RELU=1, sharing stimulus) and
//            N_IN=1 for the rounding cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_output_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Group A: N_IN=4, shared by the RELU=0 and RELU=1 instances
  logic [15:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         w_we = 1'b0;
  logic [5:0]   w_addr = '0;
  logic [15:0]  w_data = '0;
  logic         b_we = 1'b0;
  logic [3:0]   b_addr = '0;
  logic [15:0]  b_data = '0;
  logic         rdy_a, rdy_r, busy_a, busy_r, ov_a, ov_r;
  logic [159:0] no_a, no_r;

  // Group 1: N_IN=1
  logic [15:0]  in1_data = '0;
  logic         in1_valid = 1'b0;
  logic         w1_we = 1'b0;
  logic [3:0]   w1_addr = '0;
  logic [15:0]  w1_data = '0;
  logic         b1_we = 1'b0;
  logic [3:0]   b1_addr = '0;
  logic [15:0]  b1_data = '0;
  logic         rdy1, busy1, ov1;
  logic [159:0] no1;

  int checks = 0;
  int failures = 0;

  dense_output_layer #(.N_IN(4), .N_OUT(10), .RELU(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_addr(b_addr),
    .b_data(b_data), .busy(busy_a), .neuron_outputs(no_a), .out_valid(ov_a));

  dense_output_layer #(.N_IN(4), .N_OUT(10), .RELU(1'b1)) dut_r (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_r),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_addr(b_addr),
    .b_data(b_data), .busy(busy_r), .neuron_outputs(no_r), .out_valid(ov_r));

  dense_output_layer #(.N_IN(1), .N_OUT(10), .RELU(1'b0)) dut_1 (
    .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid), .in_ready(rdy1),
    .w_we(w1_we), .w_addr(w1_addr), .w_data(w1_data), .b_we(b1_we), .b_addr(b1_addr),
    .b_data(b1_data), .busy(busy1), .neuron_outputs(no1), .out_valid(ov1));

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] rep(input logic [15:0] v);
    return {10{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [15:0] v);
    for (int a = 0; a < 40; a++) begin
      w_we = 1'b1; w_addr = 6'(a); w_data = v;
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] v);
    for (int a = 0; a < 10; a++) begin
      b_we = 1'b1; b_addr = 4'(a); b_data = v;
      tick();
    end
    b_we = 1'b0;
  endtask

  task automatic wr_w(input logic [5:0] a, input logic [15:0] v);
    w_we = 1'b1; w_addr = a; w_data = v;
    tick();
    w_we = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [15:0] v);
    b_we = 1'b1; b_addr = a; b_data = v;
    tick();
    b_we = 1'b0;
  endtask

  // Streams four inputs into group A and waits for the result pulse.
  // Optionally stalls between inputs and fires a weight write mid-COMPUTE.
  task automatic run_frame(input logic [15:0] x, input bit stall,
                           input bit mid_we, input logic [5:0] mid_addr,
                           input logic [15:0] mid_data);
    int cnt;
    bit bad;
    for (int j = 0; j < 4; j++) begin
      in_data = x; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (stall && j != 3) tick();
    end
    cnt = 0;
    bad = 1'b0;
    while (!ov_a && cnt < 200) begin
      if (mid_we && cnt == 5) begin
        w_we = 1'b1; w_addr = mid_addr; w_data = mid_data;
      end else begin
        w_we = 1'b0;
      end
      tick();
      cnt++;
      if (!ov_a && (rdy_a || rdy_r || !busy_a || !busy_r)) bad = 1'b1;
    end
    w_we = 1'b0;
    check("latency_a", 160'(cnt), 160'(41));
    check("ready_low_busy_high", 160'(bad), 160'(0));
    check("valid_r_aligned", 160'(ov_r), 160'(1));
    tick();
    check("valid_single_pulse", 160'({ov_a, ov_r}), 160'(0));
    check("ready_after_valid", 160'({rdy_a, rdy_r}), 160'(2'b11));
  endtask

  task automatic run_frame1(input logic [15:0] x);
    int cnt;
    in1_data = x; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    cnt = 0;
    while (!ov1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("latency_1", 160'(cnt), 160'(11));
  endtask

  initial begin
    logic [159:0] e;
    bit seen;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 160'({ov_a, ov_r, ov1}), 160'(0));
    check("rst_outputs_a", no_a, '0);
    check("rst_outputs_1", no1, '0);
    check("rst_busy", 160'({busy_a, busy_r, busy1}), 160'(0));
    check("rst_in_ready", 160'({rdy_a, rdy_r, rdy1}), 160'(3'b111));

    // ---------------- rounding, N_IN=1 ----------------
    for (int a = 0; a < 10; a++) begin
      w1_we = 1'b1; w1_addr = 4'(a); w1_data = 16'h0001;
      b1_we = 1'b1; b1_addr = 4'(a); b1_data = 16'h0000;
      tick();
    end
    w1_we = 1'b0; b1_we = 1'b0;
    run_frame1(16'h0001);
    check("round_pos_tiny", no1, rep(16'h0000));
    for (int a = 0; a < 10; a++) begin
      w1_we = 1'b1; w1_addr = 4'(a); w1_data = 16'hFFFF;
      tick();
    end
    w1_we = 1'b0;
    run_frame1(16'h0001);
    check("round_neg_floor", no1, rep(16'hFFFF));

    // ---------------- identity sum with stalls ----------------
    load_w(16'h0100);
    load_b(16'h0000);
    run_frame(16'h0100, 1'b1, 1'b0, '0, '0);
    check("identity_a", no_a, rep(16'h0400));
    check("identity_r", no_r, rep(16'h0400));

    // ---------------- bias / sign ----------------
    load_w(16'h0000);
    wr_b(4'd3, 16'hFF00);
    wr_b(4'd7, 16'h0080);
    run_frame(16'h0100, 1'b0, 1'b0, '0, '0);
    e = '0;
    e[3*16 +: 16] = 16'hFF00;
    e[7*16 +: 16] = 16'h0080;
    check("bias_sign_a", no_a, e);
    e[3*16 +: 16] = 16'h0000;
    check("bias_sign_relu", no_r, e);

    // ---------------- saturation ----------------
    load_b(16'h0000);
    load_w(16'h7FFF);
    run_frame(16'h7FFF, 1'b0, 1'b0, '0, '0);
    check("sat_pos_a", no_a, rep(16'h7FFF));
    check("sat_pos_r", no_r, rep(16'h7FFF));
    load_w(16'h8000);
    run_frame(16'h7FFF, 1'b0, 1'b0, '0, '0);
    check("sat_neg_a", no_a, rep(16'h8000));
    check("sat_neg_relu", no_r, rep(16'h0000));

    // ---------------- write gating by busy ----------------
    load_w(16'h0100);
    run_frame(16'h0100, 1'b0, 1'b1, 6'd0, 16'h0200);
    check("wr_during_compute_cur", no_a, rep(16'h0400));
    run_frame(16'h0100, 1'b0, 1'b0, '0, '0);
    check("wr_during_compute_next", no_a, rep(16'h0400));
    wr_w(6'd0, 16'h0200);
    run_frame(16'h0100, 1'b0, 1'b0, '0, '0);
    e = rep(16'h0400);
    e[15:0] = 16'h0500;
    check("wr_idle_applies", no_a, e);
    wr_w(6'd0, 16'h0100);

    // ---------------- reset mid-COMPUTE ----------------
    in_valid = 1'b1;
    in_data  = 16'h0100;
    for (int j = 0; j < 4; j++) tick();
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 160'({ov_a, ov_r}), 160'(0));
    check("midrst_outputs", no_a, '0);
    check("midrst_in_ready", 160'({rdy_a, rdy_r}), 160'(2'b11));
    check("midrst_busy", 160'({busy_a, busy_r}), 160'(0));
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (ov_a || ov_r) seen = 1'b1;
    end
    check("midrst_no_pulse", 160'(seen), 160'(0));
    run_frame(16'h0100, 1'b0, 1'b0, '0, '0);
    check("after_rst_identity", no_a, rep(16'h0400));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
